// File: rtl/ifu_seq_ctrl_pkg.sv
// Shared definitions for the fetch-stage sequencer: FSM state encoding,
// the default boot PC, and the NPC selector codes the decode stage uses to
// form redirect_valid before it reaches ifu_seq_ctrl.
// Optional feature macro: FLUSH_ON_REDIRECT_EN (see ifu_seq_ctrl.sv).
package ifu_seq_ctrl_pkg;

  // Address of the first instruction fetched after reset.
  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // Sequential fetch stride in bytes.
  localparam logic [31:0] PC_STRIDE = 32'd4;

  // Fetch-stage FSM states.
  //  S_BOOT  : one idle cycle out of reset, no request.
  //  S_FETCH : request outstanding, F holds nothing live.
  //  S_HOLD  : F holds a live instruction for D.
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  // Next-PC selector produced by the decode-stage NPC logic.
  typedef enum logic [1:0] {
    NPC_NORMAL = 2'd0,
    NPC_BRANCH = 2'd1,
    NPC_J      = 2'd2,
    NPC_JR     = 2'd3
  } npc_type_e;

  // Sequential successor of a PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_seq(input logic [31:0] pc);
    return pc + PC_STRIDE;
  endfunction

  // Upstream helper: a control transfer is a redirect only when the
  // selector is not NORMAL and the condition resolved taken.
  function automatic logic is_redirect(input npc_type_e npc_type,
                                       input logic      taken);
    return (npc_type != NPC_NORMAL) && taken;
  endfunction

endpackage

// File: rtl/ifu_seq_ctrl.sv
// Fetch-stage sequencer. Owns the F-stage PC, drives a single outstanding
// instruction-memory request, and holds one fetched instruction for D.
//
// Redirects from the decode stage are applied after the delay slot by
// default: the instruction currently in F (or being fetched) is the delay
// slot and is still delivered; the redirect is remembered in pend_q/tgt_q
// until the PC next advances.
//
// Build option FLUSH_ON_REDIRECT_EN: no delay slot. A redirect squashes F
// immediately (even under stall), drops the request for that cycle and
// restarts fetching at the target.
module ifu_seq_ctrl
  import ifu_seq_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr
);

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] tgt_q;
  logic        pend_q;
  logic        f_valid_q;
  logic [31:0] f_instr_q;

  logic [31:0] pc_d;
  logic        consume;
  logic        flush;

  // D takes F's instruction this cycle; the PC advances to pc_d.
  assign consume = (state_q == S_HOLD) && !stall;

`ifdef FLUSH_ON_REDIRECT_EN
  assign flush = redirect_valid;
`else
  assign flush = 1'b0;
`endif

  // Next PC: a live redirect wins, then a remembered one, else sequential.
  always_comb begin
    pc_d = pc_seq(pc_q);
    if (redirect_valid) begin
      pc_d = redirect_target;
    end else if (pend_q) begin
      pc_d = tgt_q;
    end
  end

  // Request is level-held in S_FETCH and issued speculatively for the
  // successor whenever D consumes; a flushing redirect suppresses it so
  // no stale ack can be accepted in that cycle.
  always_comb begin
    imem_req  = !flush && ((state_q == S_FETCH) || consume);
    imem_addr = consume ? pc_d : pc_q;
  end

  assign f_valid = f_valid_q;
  assign f_pc    = pc_q;
  assign f_instr = f_instr_q;

  // Fetch FSM together with the PC, held instruction and pending-redirect registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_BOOT;
      pc_q      <= PC_RESET;
      tgt_q     <= 32'd0;
      pend_q    <= 1'b0;
      f_valid_q <= 1'b0;
      f_instr_q <= 32'd0;
    end else if (flush) begin
      // Squash whatever F holds and restart at the target.
      state_q   <= S_FETCH;
      pc_q      <= redirect_target;
      f_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_BOOT: begin
          // Acks here belong to no request of ours and are ignored.
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          if (imem_ack) begin
            f_instr_q <= imem_rdata;
            f_valid_q <= 1'b1;
            state_q   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            pc_q <= pc_d;
            if (imem_ack) begin
              // Back-to-back: the successor arrived in the consume cycle.
              f_instr_q <= imem_rdata;
            end else begin
              f_valid_q <= 1'b0;
              state_q   <= S_FETCH;
            end
          end
        end
        default: begin
          state_q <= S_BOOT;
        end
      endcase

`ifndef FLUSH_ON_REDIRECT_EN
      // The remembered target is consumed when the PC advances; otherwise
      // the latest redirect overwrites any earlier one.
      if (consume) begin
        pend_q <= 1'b0;
      end else if (redirect_valid) begin
        pend_q <= 1'b1;
        tgt_q  <= redirect_target;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ifu_seq_ctrl.sv
// Testbench for ifu_seq_ctrl: directed scenarios followed by randomized
// stall/ack/redirect traffic checked against a stream-level model of the
// delivered instruction sequence.
module tb_ifu_seq_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;

  int n_tests = 0;
  int n_fail  = 0;

  ifu_seq_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .f_valid        (f_valid),
    .f_pc           (f_pc),
    .f_instr        (f_instr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF ^ {a[31:16], 16'h0};
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the next falling edge (inputs are changed there).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  // Stream-level model state for the random phase.
  logic [31:0] exp_pc;
  logic        m_pend;
  logic [31:0] m_tgt;
  logic        prev_req_noack;
  logic [31:0] prev_addr;
  int          idle;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_target = 32'd0; imem_ack = 1'b0;
    #1 reset = 1'b1;

    // 1: reset state, then first request at PC_RESET
    next_cycle(); next_cycle();
    #1;
    check("rst_f_pc", f_pc, 32'h3000);
    check("rst_f_valid", f_valid, 0);
    check("rst_req", imem_req, 0);
    next_cycle();
    reset = 1'b0;
    #1 check("boot_req", imem_req, 0);
    imem_ack = 1'b1;
    next_cycle(); #1;
    check("fetch_req", imem_req, 1);
    check("fetch_addr", imem_addr, 32'h3000);
    check("fetch_f_valid", f_valid, 0);

    // 2: same-cycle ack every cycle, one instruction per cycle
    next_cycle(); #1;
    check("s2_pc0", f_pc, 32'h3000);
    check("s2_valid0", f_valid, 1);
    check("s2_instr0", f_instr, mem_word(32'h3000));
    check("s2_addr0", imem_addr, 32'h3004);
    next_cycle(); #1;
    check("s2_pc1", f_pc, 32'h3004);
    check("s2_instr1", f_instr, mem_word(32'h3004));

    // 3: stall three cycles holding 0x3004
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("s3_req", imem_req, 0);
      check("s3_pc", f_pc, 32'h3004);
      check("s3_instr", f_instr, mem_word(32'h3004));
      check("s3_valid", f_valid, 1);
      next_cycle();
    end
    stall = 1'b0;
    #1 check("s3_resume_addr", imem_addr, 32'h3008);
    next_cycle(); #1;
    check("s3_pc_after", f_pc, 32'h3008);
    next_cycle(); #1;
    check("s4_slot_pc", f_pc, 32'h300C);

    // 4: redirect to 0x3040 while F holds the delay slot 0x300C
    redirect_valid = 1'b1; redirect_target = 32'h3040;
    #1;
`ifdef FLUSH_ON_REDIRECT_EN
    check("s4_flush_req", imem_req, 0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("s4_flush_valid", f_valid, 0);
    check("s4_flush_addr", imem_addr, 32'h3040);
    next_cycle(); #1;
`else
    check("s4_slot_valid", f_valid, 1);
    check("s4_tgt_addr", imem_addr, 32'h3040);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
`endif
    check("s4_tgt_pc", f_pc, 32'h3040);
    check("s4_tgt_instr", f_instr, mem_word(32'h3040));

    // 5: jump to 0x3010 and delay its ack by two cycles
    redirect_valid = 1'b1; redirect_target = 32'h3010; imem_ack = 1'b0;
    next_cycle();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("s5_req", imem_req, 1);
      check("s5_addr", imem_addr, 32'h3010);
      check("s5_valid", f_valid, 0);
      next_cycle();
    end
    imem_ack = 1'b1;
    #1 check("s5_ack_addr", imem_addr, 32'h3010);
    next_cycle();
    stall = 1'b1; imem_ack = 1'b0;
    #1;
    check("s5_valid_after", f_valid, 1);
    check("s5_pc_after", f_pc, 32'h3010);
    check("s5_instr_after", f_instr, mem_word(32'h3010));

    // 6: redirect to 0x3080 while stalled
    redirect_valid = 1'b1; redirect_target = 32'h3080;
    #1;
`ifdef FLUSH_ON_REDIRECT_EN
    check("s6_flush_req", imem_req, 0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("s6_flush_valid", f_valid, 0);
    check("s6_flush_addr", imem_addr, 32'h3080);
    next_cycle();
    stall = 1'b0;
    #1 check("s6_fetch_addr", imem_addr, 32'h3080);
    next_cycle();
`else
    check("s6_stall_req", imem_req, 0);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    check("s6_held_pc", f_pc, 32'h3010);
    check("s6_held_valid", f_valid, 1);
    check("s6_held_req", imem_req, 0);
    next_cycle();
    stall = 1'b0;
    #1 check("s6_pend_addr", imem_addr, 32'h3080);
    next_cycle(); #1;
    check("s6_fetch_pc", f_pc, 32'h3080);
    check("s6_fetch_valid", f_valid, 0);
`endif
    imem_ack = 1'b1;
    next_cycle(); #1;
    check("s6_tgt_pc", f_pc, 32'h3080);
    check("s6_pend_clear_addr", imem_addr, 32'h3084);

    // Reset in the middle of an outstanding fetch
    imem_ack = 1'b0;
    next_cycle(); #1;
    check("mid_req", imem_req, 1);
    check("mid_addr", imem_addr, 32'h3084);
    #1 reset = 1'b1; imem_ack = 1'b1;
    #1;
    check("mid_rst_valid", f_valid, 0);
    check("mid_rst_req", imem_req, 0);
    check("mid_rst_pc", f_pc, 32'h3000);
    next_cycle();
    reset = 1'b0;
    next_cycle(); #1;
    check("post_rst_valid", f_valid, 0);
    check("post_rst_addr", imem_addr, 32'h3000);
    check("post_rst_req", imem_req, 1);

    // Randomized phase
    reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
    next_cycle();
    reset = 1'b0;
    next_cycle();
    exp_pc = 32'h3000; m_pend = 1'b0; m_tgt = 32'd0;
    prev_req_noack = 1'b0; prev_addr = 32'd0; idle = 0;
    for (int c = 0; c < 3000; c++) begin
      stall    = ($urandom % 4) == 0;
      imem_ack = ($urandom % 3) != 0;
`ifdef FLUSH_ON_REDIRECT_EN
      redirect_valid = 1'b0;
`else
      redirect_valid = ($urandom % 6) == 0;
`endif
      redirect_target = $urandom;
      #1;
      check("rnd_req_rule", imem_req, !(f_valid && stall));
      if (prev_req_noack) begin
        check("rnd_addr_stable", imem_addr, prev_addr);
      end
      if (f_valid) begin
        check("rnd_instr", f_instr, mem_word(f_pc));
      end
      if (f_valid && !stall) begin
        check("rnd_deliver_pc", f_pc, exp_pc);
        if (redirect_valid)  exp_pc = redirect_target;
        else if (m_pend)     exp_pc = m_tgt;
        else                 exp_pc = exp_pc + 32'd4;
        m_pend = 1'b0;
        idle = 0;
      end else begin
        if (redirect_valid) begin
          m_pend = 1'b1;
          m_tgt  = redirect_target;
        end
        idle++;
        if (idle > 100) begin
          check("rnd_progress", 32'(idle), 32'd0);
          break;
        end
      end
      prev_req_noack = imem_req && !imem_ack;
      prev_addr      = imem_addr;
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
